raster_pixel_source: RTL and testbench

- Upstream neighbour of the 32-bit video packer. Accepts a stream of per-pixel iteration counts from the compute units, maps each count to 8-bit RGB, and tags each pixel with sof/eol from internal raster counters.
- Presents one registered pixel per handshake on a valid/ready interface that the packer consumes directly.
- Frame-level run control: frames always complete once started; a frame-done pulse and a frame counter are provided for the control/status registers.

---
 rtl/raster_pixel_source_if.sv | 39 +++
 rtl/raster_pixel_source.sv | 158 +++++++++++++++
 tb/tb_raster_pixel_source.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pixel_source_if.sv
// Pixel-stream bundle between the compute units, the raster pixel source and
// the downstream 32-bit video packer.
//
// Signals:
//   in_iter  : per-pixel iteration count from the compute units
//   in_valid : in_iter is valid
//   in_ready : pixel source accepts in_iter this cycle
//   r, g, b  : 8-bit pixel colour towards the packer
//   valid    : pixel towards the packer is valid
//   ready    : packer is ready to take the pixel
//   sof, eol : start-of-frame / end-of-line tags for the presented pixel
//
// Modports:
//   master : the pixel source (consumes iterations, produces pixels)
//   slave  : the environment (compute-unit side and packer side)
interface raster_pixel_source_if #(
  parameter int ITER_W = 8
);
  logic [ITER_W-1:0] in_iter;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              valid;
  logic              ready;
  logic              sof;
  logic              eol;

  modport master (
    input  in_iter, in_valid, ready,
    output in_ready, r, g, b, valid, sof, eol
  );

  modport slave (
    output in_iter, in_valid, ready,
    input  in_ready, r, g, b, valid, sof, eol
  );
endinterface

// File: rtl/raster_pixel_source.sv
// Raster pixel source: takes one iteration count per raster position, maps it
// to RGB, tags it with sof/eol from internal x/y counters and presents it as a
// registered pixel on a valid/ready stream for the video packer.
//
// Ports:
//   aclk        : clock
//   aresetn     : synchronous active-low reset
//   run         : 1 = generate frames continuously; only looked at while idle
//                 and on the last pixel of a frame
//   px          : pixel-stream interface (master side), see raster_pixel_source_if
//   frame_done  : one-cycle pulse after the last pixel of a frame is accepted
//   frame_count : number of completed frames, wraps at 16 bits
//   busy        : frame in progress or a pixel still waiting for the packer
module raster_pixel_source #(
  parameter int X_SIZE   = 640,
  parameter int Y_SIZE   = 480,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   run,
  raster_pixel_source_if.master  px,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0]     X_LAST     = XW'(X_SIZE - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(Y_SIZE - 1);
  localparam logic [ITER_W-1:0] ITER_BLACK = ITER_W'(MAX_ITER);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      r_q, r_d;
  logic [7:0]      g_q, g_d;
  logic [7:0]      b_q, b_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic            in_ready;
  logic            acc;
  logic            last_x;
  logic            frame_end;
  logic [7:0]      c;

  // The output slot can take a new pixel when empty or when the held pixel
  // leaves in the same cycle, so full throughput needs no bubbles.
  always_comb begin
    in_ready  = (state_q == ACTIVE) && (!valid_q || px.ready);
    acc       = px.in_valid && in_ready;
    last_x    = (x_q == X_LAST);
    frame_end = acc && last_x && (y_q == Y_LAST);
    c         = px.in_iter[7:0];
  end

  // Run control: a started frame always finishes; run is only sampled on the
  // frame's last accepted pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = ACTIVE;
      ACTIVE:  if (frame_end && !run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register, raster counters and frame status. Data only changes on
  // an accept, so a stalled pixel stays stable with no path from ready to data.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    valid_d       = valid_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
    frame_done_d  = frame_end;
    frame_count_d = frame_count_q + 16'(frame_end);

    if (acc) begin
      // The black test uses every iteration bit; the colour ramp only the low byte.
      if (px.in_iter == ITER_BLACK) begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end else begin
        r_d = c;
        g_d = {c[6:0], 1'b0};
        b_d = 8'hFF - c;
      end
      sof_d   = (x_q == '0) && (y_q == '0);
      eol_d   = last_x;
      valid_d = 1'b1;

      if (last_x) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end else if (px.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      valid_q       <= valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign px.in_ready  = in_ready;
  assign px.r         = r_q;
  assign px.g         = g_q;
  assign px.b         = b_q;
  assign px.valid     = valid_q;
  assign px.sof       = sof_q;
  assign px.eol       = eol_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign busy         = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_raster_pixel_source.sv
// Testbench for raster_pixel_source on a small 8x2 raster with 10-bit
// iteration counts. An input monitor turns every accepted iteration into the
// expected pixel (colour from the mapping rules, sof/eol from the pixel's
// position in the frame) and pushes it into a queue; an output monitor pops
// and compares whenever the packer side takes a pixel.
module tb_raster_pixel_source;

  localparam int X_SIZE    = 8;
  localparam int Y_SIZE    = 2;
  localparam int ITER_W    = 10;
  localparam int MAX_ITER  = 255;
  localparam int FRAME_PIX = X_SIZE * Y_SIZE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } pix_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        run = 1'b0;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  raster_pixel_source_if #(.ITER_W(ITER_W)) pif ();

  raster_pixel_source #(
    .X_SIZE  (X_SIZE),
    .Y_SIZE  (Y_SIZE),
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .run        (run),
    .px         (pif),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .busy       (busy)
  );

  // 100 MHz clock.
  always #5 aclk = ~aclk;

  pix_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                pix_idx = 0;
  logic [15:0]       model_count = 16'h0000;
  logic              fe_prev = 1'b0;
  int                seq = 0;
  int                list_idx = 0;
  logic [ITER_W-1:0] colour_list[6] = '{10'h000, 10'h081, 10'h0FF, 10'h1FF, 10'h100, 10'h3FE};

  // Reference colour/tag for an iteration count at raster index idx.
  function automatic pix_t model_pixel(input logic [ITER_W-1:0] iter, input int idx);
    pix_t p;
    int   c;
    c = int'(iter) % 256;
    if (int'(iter) == MAX_ITER) begin
      p.r = 8'd0;
      p.g = 8'd0;
      p.b = 8'd0;
    end else begin
      p.r = 8'(c);
      p.g = 8'((2 * c) % 256);
      p.b = 8'(255 - c);
    end
    p.sof = (idx == 0);
    p.eol = ((idx % X_SIZE) == X_SIZE - 1);
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one or more cycles of random/sequenced stimulus at the falling edge.
  task automatic applyStimulus(input int cycles, input int vpct, input int rpct,
                               input int mode, input bit expect_full);
    for (int i = 0; i < cycles; i++) begin
      @(negedge aclk);
      pif.in_valid = ($urandom_range(0, 99) < vpct);
      pif.ready    = ($urandom_range(0, 99) < rpct);
      case (mode)
        0: pif.in_iter = ITER_W'(seq);
        1: pif.in_iter = ($urandom_range(0, 7) == 0) ? ITER_W'(MAX_ITER) : ITER_W'($urandom_range(0, 1023));
        default: pif.in_iter = colour_list[list_idx % 6];
      endcase
      #4;
      if (expect_full) checkOutput("full_rate_in_ready", pif.in_ready, 1);
      if (aresetn && pif.in_valid && pif.in_ready) begin
        seq++;
        list_idx++;
      end
    end
  endtask

  task automatic waitPixel(input int target);
    int n = 0;
    while (pix_idx != target && n < 200) begin
      applyStimulus(1, 100, 100, 0, 0);
      n++;
    end
    checkOutput("wait_pixel_reached", pix_idx, target);
  endtask

  task automatic pulseReset();
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #4;
  endtask

  // Input monitor: frame status checks, then model the accepted pixel.
  always @(negedge aclk) begin
    #4;
    if (!aresetn) begin
      exp_q.delete();
      pix_idx     = 0;
      model_count = 16'h0000;
      fe_prev     = 1'b0;
    end else begin
      checkOutput("frame_done", frame_done, fe_prev);
      checkOutput("frame_count", frame_count, model_count);
      fe_prev = 1'b0;
      if (pif.in_valid && pif.in_ready) begin
        exp_q.push_back(model_pixel(pif.in_iter, pix_idx));
        pix_idx++;
        if (pix_idx == FRAME_PIX) begin
          pix_idx = 0;
          model_count++;
          fe_prev = 1'b1;
        end
      end
    end
  end

  // Output monitor: compare the presented pixel with the queue head; pop on
  // consume, otherwise it must hold and block new input.
  always @(negedge aclk) begin
    #4;
    if (aresetn && pif.valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pixel: got valid=1 expected no pending pixel at %0t", $time);
      end else begin
        if (pif.ready) begin
          checkOutput("pixel", {pif.r, pif.g, pif.b, pif.sof, pif.eol}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          checkOutput("pixel_hold", {pif.r, pif.g, pif.b, pif.sof, pif.eol}, exp_q[0]);
          checkOutput("in_ready_stall", pif.in_ready, 0);
        end
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    pif.in_valid = 1'b0;
    pif.in_iter  = '0;
    pif.ready    = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #4;

    // Reset state.
    checkOutput("reset_valid", pif.valid, 0);
    checkOutput("reset_sof_eol", {pif.sof, pif.eol}, 0);
    checkOutput("reset_rgb", {pif.r, pif.g, pif.b}, 0);
    checkOutput("reset_in_ready", pif.in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_count", frame_count, 0);

    // Full throughput over two frames and a bit, starting from IDLE.
    @(negedge aclk);
    run = 1'b1;
    pif.in_valid = 1'b1;
    pif.ready = 1'b1;
    #4;
    checkOutput("idle_no_accept", pif.in_ready, 0);
    applyStimulus(8, 100, 100, 2, 1);
    applyStimulus(30, 100, 100, 1, 1);

    // Backpressure mid-line with a counting sequence.
    applyStimulus(3, 100, 100, 0, 0);
    applyStimulus(5, 100, 0, 0, 0);
    applyStimulus(10, 100, 100, 0, 0);

    // Drop run early in a frame: frame still completes, then idle.
    waitPixel(3);
    run = 1'b0;
    applyStimulus(20, 100, 100, 0, 0);
    checkOutput("idle_after_run_drop_in_ready", pif.in_ready, 0);
    checkOutput("idle_after_run_drop_busy", busy, 0);
    checkOutput("idle_after_run_drop_drained", exp_q.size(), 0);
    run = 1'b1;
    applyStimulus(20, 100, 100, 0, 0);

    // Reset in the middle of a frame with a pixel held.
    waitPixel(5);
    checkOutput("valid_before_reset", pif.valid, 1);
    pulseReset();
    checkOutput("valid_after_reset", pif.valid, 0);
    checkOutput("count_after_reset", frame_count, 0);
    applyStimulus(20, 100, 100, 0, 0);

    // Random gaps on both sides over exactly three frames.
    pulseReset();
    run = 1'b1;
    cyc = 0;
    while (!(model_count == 16'd3 && exp_q.size() == 0 && !pif.valid) && cyc < 3000) begin
      if (model_count >= 16'd2) run = 1'b0;
      applyStimulus(1, 50, 70, 1, 0);
      cyc++;
    end
    checkOutput("random_phase_done", (cyc < 3000), 1);
    checkOutput("frames_after_random", frame_count, 3);

    // Frame counter wrap.
    applyStimulus(2, 0, 100, 1, 0);
    @(negedge aclk);
    force dut.frame_count_q = 16'hFFFF;
    model_count = 16'hFFFF;
    @(negedge aclk);
    release dut.frame_count_q;
    run = 1'b1;
    applyStimulus(2, 100, 100, 1, 0);
    run = 1'b0;
    applyStimulus(25, 100, 100, 1, 0);
    checkOutput("frame_count_wrap", frame_count, 0);
    checkOutput("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
